// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, winner codes and 7-segment constants for the pong score display.
package pong_pkg;
  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    return (s == 8'h99) ? s :
           (s[3:0] == 4'd9) ? {s[7:4] + 4'd1, 4'd0} : {s[7:4], s[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: BCD digit to active-low 7-segment pattern (bcd_i, blank_i -> seg_o); non-BCD codes blank.
module bcd_to_seg
  import pong_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0: seg_o = SEG_0;
        4'd1: seg_o = SEG_1;
        4'd2: seg_o = SEG_2;
        4'd3: seg_o = SEG_3;
        4'd4: seg_o = SEG_4;
        4'd5: seg_o = SEG_5;
        4'd6: seg_o = SEG_6;
        4'd7: seg_o = SEG_7;
        4'd8: seg_o = SEG_8;
        4'd9: seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/score_keeper.sv
// score_keeper: BCD point counters, win detection and frame-latched 7-segment digits for two players.
// Inputs: clk, rst_n (async active-low), point_p1/point_p2 (levels, rising edge scores),
// restart (pulse), frame_tick (pulse at vertical blank).
// Outputs: seg_p{1,2}_{tens,ones} (active-low), game_over, winner.
// Optional: define SCORE_BLINK_EN to blink the winner's digits at game over.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       restart,
  input  logic       frame_tick,
  output logic [6:0] seg_p1_tens,
  output logic [6:0] seg_p1_ones,
  output logic [6:0] seg_p2_tens,
  output logic [6:0] seg_p2_ones,
  output logic       game_over,
  output logic [1:0] winner
);
  if (WIN_SCORE < 1 || WIN_SCORE > 99 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("score_keeper: WIN_SCORE must be 1..99 and BLINK_FRAMES >= 1");
  end
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  logic       pt1_q, pt2_q;
  logic       rise1, rise2, hit1, hit2;
  logic [7:0] inc1, inc2;
  logic [7:0] s1_q, s1_d, s2_q, s2_d;
  logic [7:0] sh1_q, sh2_q;
  state_t     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic       blink_off;
  assign rise1 = point_p1 & ~pt1_q;
  assign rise2 = point_p2 & ~pt2_q;
  assign inc1  = bcd_inc(s1_q);
  assign inc2  = bcd_inc(s2_q);
  assign hit1  = rise1 & (inc1 == WIN_BCD);
  assign hit2  = rise2 & (inc2 == WIN_BCD);
  always_comb begin
    s1_d    = s1_q;
    s2_d    = s2_q;
    state_d = state_q;
    win_d   = win_q;
    if (restart) begin
      s1_d    = '0;
      s2_d    = '0;
      state_d = PLAY;
      win_d   = WIN_NONE;
    end else if (state_q == PLAY) begin
      s1_d = rise1 ? inc1 : s1_q;
      s2_d = rise2 ? inc2 : s2_q;
      if (hit1 | hit2) begin
        state_d = OVER;
        win_d   = {hit2, hit1};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt1_q   <= 1'b0;
      pt2_q   <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      state_q <= PLAY;
      win_q   <= WIN_NONE;
      sh1_q   <= '0;
      sh2_q   <= '0;
    end else begin
      pt1_q   <= point_p1;
      pt2_q   <= point_p2;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      win_q   <= win_d;
      // Shadow takes the pre-update scores, so a same-cycle point or restart shows at the next tick.
      if (frame_tick) begin
        sh1_q <= s1_q;
        sh2_q <= s2_q;
      end
    end
  end
`ifdef SCORE_BLINK_EN
  logic [15:0] cnt_q;
  logic        phase_q;
  state_t      sh_state_q;
  logic [1:0]  sh_win_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      sh_state_q <= PLAY;
      sh_win_q   <= WIN_NONE;
    end else begin
      if (frame_tick) begin
        sh_state_q <= state_q;
        sh_win_q   <= win_q;
      end
      if (restart) begin
        cnt_q   <= '0;
        phase_q <= 1'b1;
      end else if (frame_tick && state_q == OVER) begin
        cnt_q   <= (cnt_q == 16'(BLINK_FRAMES - 1)) ? '0 : cnt_q + 16'd1;
        phase_q <= (cnt_q == 16'(BLINK_FRAMES - 1)) ? ~phase_q : phase_q;
      end
    end
  end
  assign blink_off = (sh_state_q == OVER) & ~phase_q;
  logic blank1, blank2;
  assign blank1 = blink_off & sh_win_q[0];
  assign blank2 = blink_off & sh_win_q[1];
`else
  assign blink_off = 1'b0;
  logic blank1, blank2;
  assign blank1 = blink_off;
  assign blank2 = blink_off;
`endif
  bcd_to_seg u_p1_tens (.bcd_i(sh1_q[7:4]), .blank_i(blank1 | (sh1_q[7:4] == 4'd0)), .seg_o(seg_p1_tens));
  bcd_to_seg u_p1_ones (.bcd_i(sh1_q[3:0]), .blank_i(blank1), .seg_o(seg_p1_ones));
  bcd_to_seg u_p2_tens (.bcd_i(sh2_q[7:4]), .blank_i(blank2 | (sh2_q[7:4] == 4'd0)), .seg_o(seg_p2_tens));
  bcd_to_seg u_p2_ones (.bcd_i(sh2_q[3:0]), .blank_i(blank2), .seg_o(seg_p2_ones));
  assign game_over = (state_q == OVER);
  assign winner    = win_q;
endmodule
